// File: rtl/fifo_rd_sched_pkg.sv
// Shared state encoding, parameter defaults and counter sizing for the
// fifo read scheduler.
package fifo_rd_sched_pkg;

   localparam int DEF_BUS_WIDTH   = 16;
   localparam int DEF_ACK_TIMEOUT = 15;
   localparam int DEF_HOLDOFF     = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // Counter must hold max(ACK_TIMEOUT, HOLDOFF) without wrapping.
   function automatic int cnt_w(input int a, input int b);
      return $clog2(((a > b) ? a : b) + 1);
   endfunction

endpackage

// File: rtl/fifo_rd_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered
// last-grant pointer that moves only when a grant is actually taken.
module rr_arb2 (
   input  logic       clkout,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic last1;  // 1: consumer 1 was granted last

   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!req[1] || last1)) gnt = 2'b01;
      else if (req[1])                  gnt = 2'b10;
   end

   always_ff @(posedge clkout) begin
      if (!rst_n)                 last1 <= 1'b1;
      else if (advance && |gnt)   last1 <= gnt[1];
   end

endmodule

// File: rtl/fifo_rd_sched.sv
// Pulls words from a 1-deep CDC fifo and hands them to one of two consumers,
// with a bounded acknowledge handshake and a hold-off before the next read.
module fifo_rd_sched
   import fifo_rd_sched_pkg::*;
#(
   parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
   parameter int HOLDOFF     = DEF_HOLDOFF
) (
   input  logic                 clkout,
   input  logic                 rst_n,
   input  logic [BUS_WIDTH-1:0] fifo_dataout,
   input  logic                 fifo_empty_n,
   output logic                 fifo_rd,
   input  logic                 req0,
   input  logic                 req1,
   output logic                 vld0,
   output logic                 vld1,
   output logic [BUS_WIDTH-1:0] data_o,
   output logic                 err
);

   localparam int CW = cnt_w(ACK_TIMEOUT, HOLDOFF);

   state_e        state;
   logic [CW-1:0] cnt;
   logic [1:0]    gnt;
   logic          advance;

   assign advance = (state == ST_IDLE) && fifo_empty_n && (req0 || req1);

   rr_arb2 u_arb (
      .clkout  (clkout),
      .rst_n   (rst_n),
      .req     ({req1, req0}),
      .advance (advance),
      .gnt     (gnt)
   );

   always_ff @(posedge clkout) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         fifo_rd <= 1'b0;
         vld0    <= 1'b0;
         vld1    <= 1'b0;
         data_o  <= '0;
         err     <= 1'b0;
         cnt     <= '0;
      end else begin
         vld0 <= 1'b0;
         vld1 <= 1'b0;
         case (state)
            ST_IDLE: if (advance) begin
               data_o  <= fifo_dataout;
               vld0    <= gnt[0];
               vld1    <= gnt[1];
               fifo_rd <= 1'b1;
               cnt     <= '0;
               state   <= ST_ACK;
            end
            // A real acknowledge beats a timeout landing on the same cycle.
            ST_ACK: if (!fifo_empty_n || cnt == CW'(ACK_TIMEOUT - 1)) begin
               if (fifo_empty_n) err <= 1'b1;
               fifo_rd <= 1'b0;
               cnt     <= CW'(HOLDOFF - 1);
               state   <= ST_HOLD;
            end else begin
               cnt <= cnt + 1'b1;
            end
            ST_HOLD: if (cnt == '0) state <= ST_IDLE;
                     else           cnt   <= cnt - 1'b1;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed scenarios plus randomized fifo/consumer traffic, all checked
// cycle by cycle against a transaction-level reference model.
module tb_fifo_rd_sched;

   localparam int BW = 16;
   localparam int TO = 15;
   localparam int HO = 3;

   logic          clkout = 1'b0;
   logic          rst_n = 1'b0;
   logic [BW-1:0] fifo_dataout = '0;
   logic          fifo_empty_n = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic          fifo_rd, vld0, vld1, err;
   logic [BW-1:0] data_o;

   fifo_rd_sched #(.BUS_WIDTH(BW), .ACK_TIMEOUT(TO), .HOLDOFF(HO)) dut (
      .clkout       (clkout),
      .rst_n        (rst_n),
      .fifo_dataout (fifo_dataout),
      .fifo_empty_n (fifo_empty_n),
      .fifo_rd      (fifo_rd),
      .req0         (req0),
      .req1         (req1),
      .vld0         (vld0),
      .vld1         (vld1),
      .data_o       (data_o),
      .err          (err)
   );

   always #5 clkout = ~clkout;

   int n_tests = 0;
   int n_fail  = 0;
   int vq[$];

   // Reference model: "reading" = read ack outstanding, "cool" = edges of
   // hold-off still to elapse, "waited" = ack cycles already spent.
   bit            m_rd, m_v0, m_v1, m_err, m_last1, m_reading;
   int            m_waited, m_cool;
   logic [BW-1:0] m_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      int win;
      if (!rst_n) begin
         m_rd = 0; m_v0 = 0; m_v1 = 0; m_err = 0; m_data = '0;
         m_last1 = 1; m_reading = 0; m_cool = 0; m_waited = 0;
         return;
      end
      m_v0 = 0; m_v1 = 0;
      if (m_reading) begin
         if (!fifo_empty_n || m_waited == TO - 1) begin
            if (fifo_empty_n) m_err = 1;
            m_reading = 0; m_rd = 0; m_cool = HO;
         end else m_waited++;
      end else if (m_cool > 0) begin
         m_cool--;
      end else if (fifo_empty_n && (req0 || req1)) begin
         if (req0 && req1) win = m_last1 ? 0 : 1;
         else              win = req1 ? 1 : 0;
         m_last1 = (win == 1);
         m_v0 = (win == 0); m_v1 = (win == 1);
         m_data = fifo_dataout; m_rd = 1; m_reading = 1; m_waited = 0;
      end
   endtask

   task automatic cyc(input bit rst, input bit en, input bit r0, input bit r1,
                      input logic [BW-1:0] d);
      rst_n = rst; fifo_empty_n = en; req0 = r0; req1 = r1; fifo_dataout = d;
      @(posedge clkout);
      model_step();
      #1;
      chk("fifo_rd", fifo_rd, m_rd);
      chk("vld0", vld0, m_v0);
      chk("vld1", vld1, m_v1);
      chk("data_o", data_o, m_data);
      chk("err", err, m_err);
      chk("vld_excl", vld0 & vld1, 1'b0);
      if (vld0) vq.push_back(0);
      if (vld1) vq.push_back(1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, '0);
   endtask

   initial begin
      bit            full, r0, r1;
      logic [BW-1:0] word;

      // basic delivery, acknowledge and hold-off timing
      cyc(0, 0, 0, 0, '0); cyc(0, 0, 0, 0, '0);
      chk("rst_rd", fifo_rd, 0); chk("rst_data", data_o, 0); chk("rst_err", err, 0);
      cyc(1, 1, 1, 0, 16'hA5A5);
      chk("first_vld0", vld0, 1); chk("first_data", data_o, 16'hA5A5); chk("first_rd", fifo_rd, 1);
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 16'hA5A5);
      cyc(1, 0, 0, 0, '0);
      chk("ack_rd_drop", fifo_rd, 0);
      for (int i = 1; i <= 4; i++) begin
         cyc(1, 1, 1, 0, 16'h1234);
         chk($sformatf("holdoff_rd_%0d", i), fifo_rd, (i == 4));
      end
      cyc(1, 0, 0, 0, '0); idle(4);

      // round-robin on a persistent tie
      cyc(0, 0, 0, 0, '0);
      vq.delete();
      for (int i = 0; i < 80 && vq.size() < 4; i++) cyc(1, !m_rd, 1, 1, BW'(i));
      chk("rr_count", vq.size(), 4);
      for (int i = 0; i < 4 && i < vq.size(); i++) chk($sformatf("rr_order_%0d", i), vq[i], i % 2);
      idle(5);

      // a waiting word with no requester is left alone
      cyc(0, 0, 0, 0, '0);
      for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 16'h0F0F);
      chk("noreq_rd", fifo_rd, 0);
      cyc(1, 1, 0, 1, 16'h0F0F);
      chk("req1_vld1", vld1, 1);
      cyc(1, 0, 0, 0, '0); idle(4);

      // acknowledge arriving on the last allowed ack cycle
      cyc(0, 0, 0, 0, '0);
      cyc(1, 1, 1, 0, 16'h3C3C);
      for (int i = 0; i < TO - 1; i++) cyc(1, 1, 0, 0, 16'h3C3C);
      cyc(1, 0, 0, 0, '0);
      chk("late_ack_err", err, 0); chk("late_ack_rd", fifo_rd, 0);
      idle(4);

      // acknowledge timeout, sticky err, redelivery
      cyc(1, 1, 1, 0, 16'hBEEF);
      for (int i = 1; i <= TO; i++) begin
         cyc(1, 1, 0, 0, 16'hBEEF);
         chk($sformatf("to_rd_%0d", i), fifo_rd, (i < TO));
      end
      chk("to_err", err, 1);
      for (int i = 0; i < HO; i++) cyc(1, 1, 0, 0, 16'hBEEF);
      cyc(1, 1, 1, 0, 16'hBEEF);
      chk("redeliver_vld0", vld0, 1); chk("redeliver_data", data_o, 16'hBEEF);
      cyc(1, 0, 0, 0, '0); idle(4);
      chk("err_sticky", err, 1);

      // reset during ACK
      cyc(1, 1, 0, 1, 16'h7777);
      cyc(1, 1, 0, 0, 16'h7777);
      cyc(0, 1, 1, 1, 16'h7777);
      chk("rst_ack_rd", fifo_rd, 0); chk("rst_ack_err", err, 0);
      chk("rst_ack_data", data_o, 0); chk("rst_ack_vld", {vld1, vld0}, 0);

      // randomized fifo and consumer traffic
      full = 0; word = '0; r0 = 0; r1 = 0;
      for (int i = 0; i < 4000; i++) begin
         if (m_rd && full && ($urandom_range(0, 19) != 0)) full = 0;
         else if (!full && !m_rd && ($urandom_range(0, 2) == 0)) begin
            full = 1; word = BW'($urandom);
         end
         if ($urandom_range(0, 3) == 0) r0 = $urandom_range(0, 1);
         if ($urandom_range(0, 3) == 0) r1 = $urandom_range(0, 1);
         cyc($urandom_range(0, 499) != 0, full, r0, r1, word);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
